vga_timing: RTL
===============

Name: vga_timing

Overview:
- Parametrised successor to the fixed 80x24 text-mode raster timing block; it generates the pixel-clock raster for a glyph-based display.
- Per-axis glyph/pixel geometry, porches, sync width and sync polarity are all parameters.
- Adds a configurable output delay line so that de/sync/glyph align with a downstream glyph-ROM/attribute pipeline of LATENCY stages.
- Adds line/frame strobes and a frame-counted blink bit for cursor/attribute blinking. Sits between the pixel clock and the character generator.

Parameters:
- H_GLYPHS, 80, glyph columns per line
- H_PIXELS, 10, pixels per glyph column
- H_FRONT, 36, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 46, horizontal back porch (clocks)
- H_POL, 0, hsync active level (0 = active-low)
- V_GLYPHS, 24, glyph rows per frame
- V_PIXELS, 20, lines per glyph row
- V_FRONT, 7, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 23, vertical back porch (lines)
- V_POL, 0, vsync active level
- LATENCY, 0, delay stages applied to de/hsync/vsync/glyph/line_start/frame_start relative to the coordinates (0..8)
- BLINK_W, 5, frame-counter width; blink = MSB

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- de  out  1  display enable, delayed LATENCY clocks
- hsync  out  1  horizontal sync at H_POL level when active, delayed LATENCY clocks
- vsync  out  1  vertical sync at V_POL level when active, delayed LATENCY clocks
- glyph  out  1  strobe on pixel 0 of each active glyph, delayed LATENCY clocks
- line_start  out  1  one-clock strobe on the first active pixel of each active line, delayed LATENCY clocks
- frame_start  out  1  one-clock strobe on the first active pixel of the frame, delayed LATENCY clocks
- h_glyph  out  clog2(H_GLYPHS)  column, undelayed
- h_pixel  out  clog2(H_PIXELS)  pixel within column, undelayed
- v_glyph  out  clog2(V_GLYPHS)  row, undelayed
- v_pixel  out  clog2(V_PIXELS)  line within row, undelayed
- blink  out  1  frame_count[BLINK_W-1]

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Axis sequence: each axis steps ACTIVE (GLYPHS*PIXELS) -> FRONT -> SYNC -> BACK -> ACTIVE.
  - H total = H_GLYPHS*H_PIXELS + H_FRONT + H_SYNC + H_BACK clocks.
  - V total is the sum of the V parameters, in lines.
- Axis counters:
  - The pixel counter runs 0..PIXELS-1. The glyph counter increments when pixel wraps.
  - Both counters hold 0 outside ACTIVE.
- Carries:
  - The H axis advances every clock.
  - H carry is high on the last BACK clock. It advances the V axis.
  - V carry, qualified with H carry, marks the frame end and increments frame_count, which wraps modulo 2^BLINK_W.
- Reset state: the last clock of the frame (H last BACK clock, V last BACK line), with frame_count=0 and every delay stage cleared.
  - de=0, glyph=0, line_start=0, frame_start=0, hsync=!H_POL, vsync=!V_POL, coordinates 0, blink=0.
  - The first rising edge after release enters pixel (0,0). Undelayed frame_start is then high for that clock.
- Combinational raw terms, from the registered axis state:
  - de_raw = h_active & v_active.
  - glyph_raw = de_raw & (h_pixel==0).
  - line_start_raw = de_raw & h_glyph==0 & h_pixel==0.
  - frame_start_raw = line_start_raw & v_glyph==0 & v_pixel==0.
  - hsync_raw and vsync_raw are active in the respective SYNC phase.
- Delay line:
  - LATENCY=0: outputs equal the raw terms.
  - LATENCY=N: an N-stage shift register. Output at cycle t equals raw at t-N.
  - Coordinates and blink are never delayed; they lead by LATENCY.
- Sync timing: the vertical phase changes only at H carry, so vsync edges coincide with the start of the H ACTIVE phase (raw domain).
- Reset mid-frame: all state returns to the reset state asynchronously, including the delay line. No partial strobes appear after release.
- Elaboration checks: each of GLYPHS, PIXELS, SYNC must be >=1; FRONT, BACK >=1; LATENCY <=8. Violations fail elaboration.

Decomposition:
- Shared package vga_pkg:
  - phase enum {ACTIVE, FRONT, SYNC, BACK} (2 bits).
  - default 80x24 geometry constants.
  - clog2 helper for the port widths.
- Sub-module vga_axis_gen: one parametrised axis.
  - Inputs: clk, reset, ce.
  - Outputs: active, sync (active-high), carry, glyph, pixel.
  - Instantiated twice: the H axis with ce=1, the V axis with ce=H carry.
- The top level holds the raw terms, polarity, delay line and frame counter.

Test Plan:
- Small raster: H 4x2, FP2, SYNC3, BP1 (14 clocks); V 2x2, FP1, SYNC2, BP1 (8 lines); LATENCY=0. After release:
  - de high for clocks 0-7 of lines 0-3.
  - hsync low at clocks 10-12 of every line.
  - vsync low for lines 5-6.
  - frame_start repeats every 112 clocks.
- Same raster with H_POL=1, V_POL=1: hsync and vsync are high in the same windows and low elsewhere; reset level is 0.
- Coordinates: glyph pulses at clocks 0,2,4,6 of each active line, with h_glyph 0..3 at those pulses; line_start on clock 0 of lines 0-3 only; v_glyph=1 on lines 2-3.
- LATENCY=3: de, sync and strobes are identical to LATENCY=0 shifted by exactly 3 clocks; coordinates are unchanged.
- BLINK_W=2: blink is 0 for frames 0-1, 1 for frames 2-3, and 0 again at frame 4.
- Reset asserted mid-active-line (line 2, clock 5) for 3 clocks:
  - During reset, outputs are at reset values immediately, without waiting for a clk edge.
  - After release, the first edge gives frame_start with (0,0) and blink=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the glyph-raster timing generator.
// Holds the axis phase encoding, the default 80x24 geometry and the port-width helper.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_e;

    localparam int DEF_H_GLYPHS = 80;
    localparam int DEF_H_PIXELS = 10;
    localparam int DEF_H_FRONT  = 36;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 46;
    localparam int DEF_V_GLYPHS = 24;
    localparam int DEF_V_PIXELS = 20;
    localparam int DEF_V_FRONT  = 7;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 23;

    // Never returns 0, so a single-valued counter still gets a 1-bit port.
    function automatic int vga_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_axis_gen.sv
// One raster axis: ACTIVE (glyphs x pixels) -> FRONT -> SYNC -> BACK, advancing when ce_i is high.
// Resets to the last BACK step so the first enabled step enters glyph 0, pixel 0.
module vga_axis_gen
    import vga_pkg::*;
#(
    parameter int N_GLYPHS = DEF_H_GLYPHS,
    parameter int N_PIXELS = DEF_H_PIXELS,
    parameter int N_FRONT  = DEF_H_FRONT,
    parameter int N_SYNC   = DEF_H_SYNC,
    parameter int N_BACK   = DEF_H_BACK,
    localparam int GW = vga_clog2(N_GLYPHS),
    localparam int PW = vga_clog2(N_PIXELS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ce_i,
    output logic          active_o,
    output logic          sync_o,
    output logic          carry_o,
    output logic [GW-1:0] glyph_o,
    output logic [PW-1:0] pixel_o
);

    localparam int LMAX = (N_FRONT > N_SYNC) ? ((N_FRONT > N_BACK) ? N_FRONT : N_BACK)
                                             : ((N_SYNC > N_BACK) ? N_SYNC : N_BACK);
    localparam int CW = vga_clog2(LMAX);

    localparam logic [PW-1:0] PIX_LAST   = PW'(N_PIXELS - 1);
    localparam logic [GW-1:0] GLY_LAST   = GW'(N_GLYPHS - 1);
    localparam logic [CW-1:0] FRONT_LAST = CW'(N_FRONT - 1);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(N_SYNC - 1);
    localparam logic [CW-1:0] BACK_LAST  = CW'(N_BACK - 1);

    if (N_GLYPHS < 1 || N_PIXELS < 1 || N_SYNC < 1 || N_FRONT < 1 || N_BACK < 1) begin : g_bad_geometry
        $error("vga_axis_gen: every glyph/pixel/porch/sync length must be >= 1");
    end

    phase_e        phase_q, phase_d;
    logic [GW-1:0] glyph_q, glyph_d;
    logic [PW-1:0] pixel_q, pixel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_d = phase_q;
        glyph_d = glyph_q;
        pixel_d = pixel_q;
        cnt_d   = cnt_q;
        if (ce_i) begin
            case (phase_q)
                ACTIVE: begin
                    if (pixel_q == PIX_LAST) begin
                        pixel_d = '0;
                        if (glyph_q == GLY_LAST) begin
                            glyph_d = '0;
                            cnt_d   = '0;
                            phase_d = FRONT;
                        end else begin
                            glyph_d = glyph_q + 1'b1;
                        end
                    end else begin
                        pixel_d = pixel_q + 1'b1;
                    end
                end
                FRONT: begin
                    if (cnt_q == FRONT_LAST) begin
                        cnt_d   = '0;
                        phase_d = SYNC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_q == SYNC_LAST) begin
                        cnt_d   = '0;
                        phase_d = BACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == BACK_LAST) begin
                        cnt_d   = '0;
                        phase_d = ACTIVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q <= BACK;
            cnt_q   <= BACK_LAST;
            glyph_q <= '0;
            pixel_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            glyph_q <= glyph_d;
            pixel_q <= pixel_d;
        end
    end

    assign active_o = (phase_q == ACTIVE);
    assign sync_o   = (phase_q == SYNC);
    assign carry_o  = (phase_q == BACK) && (cnt_q == BACK_LAST);
    assign glyph_o  = glyph_q;
    assign pixel_o  = pixel_q;

endmodule

// File: rtl/vga_timing.sv
// Glyph-raster timing generator: H/V axes, raw strobes, a LATENCY-stage alignment delay
// for de/sync/strobes, and a frame counter whose MSB drives the blink bit.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_GLYPHS = DEF_H_GLYPHS,
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter bit H_POL    = 1'b0,
    parameter int V_GLYPHS = DEF_V_GLYPHS,
    parameter int V_PIXELS = DEF_V_PIXELS,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit V_POL    = 1'b0,
    parameter int LATENCY  = 0,
    parameter int BLINK_W  = 5,
    localparam int HGW = vga_clog2(H_GLYPHS),
    localparam int HPW = vga_clog2(H_PIXELS),
    localparam int VGW = vga_clog2(V_GLYPHS),
    localparam int VPW = vga_clog2(V_PIXELS)
) (
    input  logic           clk,
    input  logic           reset,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           glyph,
    output logic           line_start,
    output logic           frame_start,
    output logic [HGW-1:0] h_glyph,
    output logic [HPW-1:0] h_pixel,
    output logic [VGW-1:0] v_glyph,
    output logic [VPW-1:0] v_pixel,
    output logic           blink
);

    if (LATENCY < 0 || LATENCY > 8 || BLINK_W < 1) begin : g_bad_config
        $error("vga_timing: LATENCY must be 0..8 and BLINK_W >= 1");
    end

    logic h_active, h_sync, h_carry;
    logic v_active, v_sync, v_carry;

    vga_axis_gen #(
        .N_GLYPHS(H_GLYPHS), .N_PIXELS(H_PIXELS),
        .N_FRONT(H_FRONT), .N_SYNC(H_SYNC), .N_BACK(H_BACK)
    ) u_h_axis (
        .clk_i(clk), .reset_i(reset), .ce_i(1'b1),
        .active_o(h_active), .sync_o(h_sync), .carry_o(h_carry),
        .glyph_o(h_glyph), .pixel_o(h_pixel)
    );

    vga_axis_gen #(
        .N_GLYPHS(V_GLYPHS), .N_PIXELS(V_PIXELS),
        .N_FRONT(V_FRONT), .N_SYNC(V_SYNC), .N_BACK(V_BACK)
    ) u_v_axis (
        .clk_i(clk), .reset_i(reset), .ce_i(h_carry),
        .active_o(v_active), .sync_o(v_sync), .carry_o(v_carry),
        .glyph_o(v_glyph), .pixel_o(v_pixel)
    );

    logic de_raw, glyph_raw, line_start_raw, frame_start_raw;
    logic [5:0] raw_vec, out_vec;

    assign de_raw          = h_active & v_active;
    assign glyph_raw       = de_raw & (h_pixel == '0);
    assign line_start_raw  = glyph_raw & (h_glyph == '0);
    assign frame_start_raw = line_start_raw & (v_glyph == '0) & (v_pixel == '0);
    assign raw_vec = {de_raw, h_sync, v_sync, glyph_raw, line_start_raw, frame_start_raw};

    // Stages hold active-high terms; polarity is applied after, so cleared stages read as inactive.
    if (LATENCY == 0) begin : g_no_delay
        assign out_vec = raw_vec;
    end else begin : g_delay
        logic [5:0] dly_q [LATENCY];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LATENCY; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= raw_vec;
                for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign out_vec = dly_q[LATENCY-1];
    end

    assign de          = out_vec[5];
    assign hsync       = H_POL ? out_vec[4] : ~out_vec[4];
    assign vsync       = V_POL ? out_vec[3] : ~out_vec[3];
    assign glyph       = out_vec[2];
    assign line_start  = out_vec[1];
    assign frame_start = out_vec[0];

    // The reset state already sits on the frame-end clock; started_q keeps that first
    // carry from counting, so frame 0 runs with frame_count == 0.
    logic [BLINK_W-1:0] frame_count_q, frame_count_d;
    logic               started_q;

    assign frame_count_d = (h_carry & v_carry & started_q) ? frame_count_q + 1'b1 : frame_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
            started_q     <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            started_q     <= 1'b1;
        end
    end

    assign blink = frame_count_q[BLINK_W-1];

endmodule
